cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_pkg.sv | 31 +++
 rtl/cp0_irq_arb.sv | 25 ++
 rtl/cp0_ctrl.sv | 130 +++++++++++++
 tb/tb_cp0_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, SR/Cause
// bit positions and the processor ID value.
package cp0_pkg;

  // CP0 register addresses
  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // Exception codes carried in Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR field positions
  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;

  // Cause field positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD     = 31;

  // Processor ID returned by mfc0 of PRId
  localparam logic [31:0] PRID_VALUE = 32'h0000_0007;

endpackage

// File: rtl/cp0_irq_arb.sv
// Combinational interrupt/exception arbiter for CP0. Decides whether the
// M-stage victim is taken and which ExcCode is recorded; the interrupt
// outranks a synchronous exception. Holds no state.
module cp0_irq_arb
  import cp0_pkg::*;
(
  input  logic       i_reset,
  input  logic [5:0] i_hwint,
  input  logic [5:0] i_im,
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [4:0] i_exc_code,
  output logic       o_int_req,
  output logic       o_exc_req,
  output logic       o_req,
  output logic [4:0] o_exc_code_sel
);

  // Request terms, all masked while a handler is active (EXL = 1)
  assign o_int_req      = (|(i_hwint & i_im)) & i_ie & ~i_exl;
  assign o_exc_req      = (i_exc_code != 5'd0) & ~i_exl;
  assign o_req          = (o_int_req | o_exc_req) & ~i_reset;
  assign o_exc_code_sel = o_int_req ? EXC_INT : i_exc_code;

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 control block: SR, Cause, EPC and PRId with mtc0/mfc0 access,
// exception/interrupt entry and eret exit.
// Build option: define CP0_BD_EN to capture the branch-delay flag (Cause.BD)
// and rewind EPC by 4 for delay-slot victims; otherwise BDIn is ignored.
//
// Handshake: Req is a single-cycle combinational strobe with no ready side.
// The pipeline must flush/redirect in the cycle Req is high; CP0 commits
// the exception entry at the closing posedge of that same cycle.
module cp0_ctrl
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [4:0]  w_exc_code_sel;
  logic        w_bd;
  logic [31:0] w_epc_next;
  logic [31:0] w_cp0_out;
  logic        w_wr_sr;
  logic        w_wr_epc;

`ifdef CP0_BD_EN
  assign w_bd = BDIn;
`else
  logic w_unused_bd;
  assign w_unused_bd = BDIn;
  assign w_bd        = 1'b0;
`endif

  // Delay-slot victims return to the branch, one word earlier
  assign w_epc_next = w_bd ? (VPC - 32'd4) : VPC;

  assign w_wr_sr  = en && (CP0Add == ADDR_SR);
  assign w_wr_epc = en && (CP0Add == ADDR_EPC);

  cp0_irq_arb u_arb (
    .i_reset        (reset),
    .i_hwint        (HWInt),
    .i_im           (r_im),
    .i_ie           (r_ie),
    .i_exl          (r_exl),
    .i_exc_code     (ExcCodeIn),
    .o_int_req      (w_int_req),
    .o_exc_req      (w_exc_req),
    .o_req          (w_req),
    .o_exc_code_sel (w_exc_code_sel)
  );

  // Register update: reset, then exception entry (drops any mtc0), else mtc0 and eret
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_exccode <= w_exc_code_sel;
        r_bd      <= w_bd;
        r_epc     <= w_epc_next;
      end else begin
        if (w_wr_sr) begin
          r_im  <= CP0In[SR_IM_LO +: 6];
          r_exl <= CP0In[SR_EXL];
          r_ie  <= CP0In[SR_IE];
        end
        if (w_wr_epc) begin
          r_epc <= CP0In;
        end
        // eret overrides a same-cycle SR write for the EXL bit only
        if (EXLClr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read mux straight from register contents
  always_comb begin
    w_cp0_out = '0;
    case (CP0Add)
      ADDR_SR: begin
        w_cp0_out[SR_IM_LO +: 6] = r_im;
        w_cp0_out[SR_EXL]        = r_exl;
        w_cp0_out[SR_IE]         = r_ie;
      end
      ADDR_CAUSE: begin
        w_cp0_out[CAUSE_BD]            = r_bd;
        w_cp0_out[CAUSE_IP_LO +: 6]    = r_ip;
        w_cp0_out[CAUSE_EXC_LO +: 5]   = r_exccode;
      end
      ADDR_EPC:  w_cp0_out = r_epc;
      ADDR_PRID: w_cp0_out = PRID_VALUE;
      default:   w_cp0_out = '0;
    endcase
  end

  assign CP0Out = w_cp0_out;
  assign EPCOut = w_wr_epc ? CP0In : r_epc;
  assign Req    = w_req;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Bench for cp0_ctrl: directed vectors drive the block #1 after each posedge
// and push expected values; a monitor drains the queue at each negedge.
module tb_cp0_ctrl;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  // Observation selectors
  localparam int OBS_CP0OUT = 0;
  localparam int OBS_REQ    = 1;
  localparam int OBS_EPCOUT = 2;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];

  int n_vec  = 0;
  int n_fail = 0;

`ifdef CP0_BD_EN
  localparam logic [31:0] EXP_CAUSE_DS = 32'h8000_0030;
  localparam logic [31:0] EXP_EPC_DS   = 32'h0000_3020;
`else
  localparam logic [31:0] EXP_CAUSE_DS = 32'h0000_0030;
  localparam logic [31:0] EXP_EPC_DS   = 32'h0000_3024;
`endif

  cp0_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Add    (CP0Add),
    .CP0In     (CP0In),
    .CP0Out    (CP0Out),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en        = 1'b0;
    CP0Add    = 5'd0;
    CP0In     = 32'd0;
    VPC       = 32'd0;
    BDIn      = 1'b0;
    ExcCodeIn = 5'd0;
    HWInt     = 6'd0;
    EXLClr    = 1'b0;
  endtask

  task automatic push_exp(input int sel, input logic [31:0] v, input string nm);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] v, input string nm);
    CP0Add = a;
    push_exp(OBS_CP0OUT, v, nm);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    en     = 1'b1;
    CP0Add = a;
    CP0In  = d;
  endtask

  // Scoreboard monitor: compare everything queued for this cycle
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        automatic int          s  = sel_q.pop_front();
        automatic logic [31:0] e  = exp_q.pop_front();
        automatic string       nm = name_q.pop_front();
        automatic logic [31:0] a;
        case (s)
          OBS_CP0OUT: a = CP0Out;
          OBS_REQ:    a = {31'd0, Req};
          default:    a = EPCOut;
        endcase
        n_vec++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    idle();
    reset = 1'b1;
    cyc();
    ExcCodeIn = 5'd10;
    HWInt     = 6'h3F;
    push_exp(OBS_REQ, 32'd0, "req_in_reset_a");
    cyc();
    push_exp(OBS_REQ, 32'd0, "req_in_reset_b");
    cyc();
    reset = 1'b0;
    idle();
    rd(5'd12, 32'd0, "reset_sr");
    push_exp(OBS_REQ, 32'd0, "reset_req");
    cyc();
    rd(5'd13, 32'd0, "reset_cause");
    cyc();
    rd(5'd14, 32'd0, "reset_epc");
    cyc();
    rd(5'd15, 32'h0000_0007, "prid");
    cyc();
    rd(5'd3, 32'd0, "unmapped");
    cyc();
    // Writes to Cause and PRId are ignored
    mtc0(5'd13, 32'hFFFF_FFFF);
    cyc();
    mtc0(5'd15, 32'hFFFF_FFFF);
    cyc();
    idle();
    rd(5'd13, 32'd0, "cause_wr_ignored");
    cyc();
    rd(5'd15, 32'h0000_0007, "prid_wr_ignored");
    cyc();

    // Interrupt entry
    mtc0(5'd12, 32'h0000_0401);
    push_exp(OBS_REQ, 32'd0, "sr_write_noreq");
    cyc();
    idle();
    rd(5'd12, 32'h0000_0401, "sr_after_mtc0");
    HWInt = 6'b000001;
    VPC   = 32'h3010;
    push_exp(OBS_REQ, 32'd1, "int_req");
    cyc();
    idle();
    push_exp(OBS_REQ, 32'd0, "int_masked_exl");
    rd(5'd13, 32'h0000_0400, "int_cause");
    cyc();
    rd(5'd12, 32'h0000_0403, "int_sr_exl");
    cyc();
    rd(5'd14, 32'h0000_3010, "int_epc");
    push_exp(OBS_EPCOUT, 32'h0000_3010, "int_epcout");
    cyc();
    EXLClr = 1'b1;
    cyc();
    idle();
    rd(5'd12, 32'h0000_0401, "eret_sr");
    cyc();

    // Masking: IE = 0, then IM = 0
    mtc0(5'd12, 32'h0000_0400);
    cyc();
    idle();
    HWInt = 6'h3F;
    push_exp(OBS_REQ, 32'd0, "mask_ie0");
    cyc();
    push_exp(OBS_REQ, 32'd0, "mask_ie0_b");
    rd(5'd13, 32'h0000_FC00, "mask_cause_ip");
    cyc();
    mtc0(5'd12, 32'h0000_0001);
    push_exp(OBS_REQ, 32'd0, "mask_wr_cycle");
    cyc();
    idle();
    HWInt = 6'h3F;
    push_exp(OBS_REQ, 32'd0, "mask_im0");
    cyc();
    idle();
    cyc();

    // Exception in a delay slot (SR = IE only, EXL = 0)
    ExcCodeIn = 5'd12;
    BDIn      = 1'b1;
    VPC       = 32'h3024;
    push_exp(OBS_REQ, 32'd1, "exc_req");
    cyc();
    idle();
    push_exp(OBS_REQ, 32'd0, "exc_masked_exl");
    rd(5'd13, EXP_CAUSE_DS, "exc_cause");
    cyc();
    rd(5'd14, EXP_EPC_DS, "exc_epc");
    cyc();
    rd(5'd12, 32'h0000_0003, "exc_sr");
    cyc();

    // eret with EPC bypass, exception pending but masked by EXL
    mtc0(5'd14, 32'h3100);
    EXLClr    = 1'b1;
    ExcCodeIn = 5'd5;
    push_exp(OBS_EPCOUT, 32'h0000_3100, "epc_bypass");
    push_exp(OBS_CP0OUT, EXP_EPC_DS, "epc_reg_before_wr");
    push_exp(OBS_REQ, 32'd0, "eret_pending_masked");
    cyc();
    idle();
    ExcCodeIn = 5'd5;
    VPC       = 32'h3200;
    rd(5'd12, 32'h0000_0001, "eret_exl_clear");
    push_exp(OBS_REQ, 32'd1, "pending_req");
    cyc();
    idle();
    rd(5'd13, 32'h0000_0014, "ades_cause");
    cyc();
    rd(5'd14, 32'h0000_3200, "ades_epc");
    cyc();

    // eret + mtc0 SR same cycle: EXLClr wins for EXL
    mtc0(5'd12, 32'h0000_FC03);
    EXLClr = 1'b1;
    cyc();
    idle();
    rd(5'd12, 32'h0000_FC01, "eret_mtc0_sr");
    cyc();

    // Collision: mtc0 SR dropped, exception wins
    mtc0(5'd12, 32'd0);
    ExcCodeIn = 5'd4;
    VPC       = 32'h3300;
    push_exp(OBS_REQ, 32'd1, "collide_req");
    cyc();
    idle();
    rd(5'd12, 32'h0000_FC03, "collide_sr");
    cyc();
    rd(5'd13, 32'h0000_0010, "collide_cause");
    cyc();
    rd(5'd14, 32'h0000_3300, "collide_epc");
    cyc();

    // Reset mid-handler (EXL = 1)
    reset     = 1'b1;
    ExcCodeIn = 5'd10;
    HWInt     = 6'h3F;
    push_exp(OBS_REQ, 32'd0, "midreset_req_a");
    cyc();
    push_exp(OBS_REQ, 32'd0, "midreset_req_b");
    cyc();
    reset = 1'b0;
    idle();
    rd(5'd12, 32'd0, "midreset_sr");
    cyc();
    rd(5'd13, 32'd0, "midreset_cause");
    cyc();
    rd(5'd14, 32'd0, "midreset_epc");
    ExcCodeIn = 5'd10;
    push_exp(OBS_REQ, 32'd1, "post_reset_req");
    cyc();
    idle();

    // Drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
